// File: rtl/unidade_controle_fsm_pkg.sv
// uc_pkg: opcodes and state encoding shared by the multicycle control unit
package uc_pkg;
  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T0   = 3'd1;
  localparam logic [2:0] S_T1   = 3'd2;
  localparam logic [2:0] S_T2   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;
  typedef enum logic [2:0] {
    IDLE = S_IDLE,
    T0   = S_T0,
    T1   = S_T1,
    T2   = S_T2,
    T3   = S_T3
  } uc_state_t;
endpackage

// File: rtl/unidade_controle_fsm_if.sv
// unidade_controle_fsm_if: start/instruction inputs and datapath control enables
// master = control unit (drives enables), slave = datapath side (drives Run/Instrucao/GNZ)
interface unidade_controle_fsm_if #(parameter int NREG = 8);
  localparam int RSEL_W = $clog2(NREG);
  localparam int IW = 3 + 2 * RSEL_W;
  logic            Run;
  logic [IW-1:0]   Instrucao;
  logic            GNZ;
  logic            IRin;
  logic [NREG-1:0] Rin;
  logic [NREG-1:0] Rout;
  logic            Ain;
  logic            Gin;
  logic            Gout;
  logic            DINout;
  logic            AddSub;
  logic            Done;
  logic            Busy;
  logic            Illegal;
  modport master (
    input  Run, Instrucao, GNZ,
    output IRin, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done, Busy, Illegal
  );
  modport slave (
    output Run, Instrucao, GNZ,
    input  IRin, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done, Busy, Illegal
  );
endinterface

// File: rtl/unidade_controle_fsm_dec_onehot.sv
// dec_onehot: W-bit binary index to 2^W-bit one-hot vector
// ports: a_i binary index, y_o one-hot result
module dec_onehot #(parameter int W = 3) (
  input  logic [W-1:0]      a_i,
  output logic [2**W-1:0]   y_o
);
  assign y_o = {{(2**W-1){1'b0}}, 1'b1} << a_i;
endmodule

// File: rtl/unidade_controle_fsm.sv
// unidade_controle_fsm: fetch/execute sequencer for the multicycle datapath
// ports: Clock, Reset (async, active-high), bus (master modport: Run/Instrucao/GNZ in, enables out)
// optional mvnz opcode compiled in with UC_MVNZ_EN
module unidade_controle_fsm import uc_pkg::*; #(
  parameter int NREG   = 8,
  parameter int RSEL_W = $clog2(NREG),
  parameter int IW     = 3 + 2 * RSEL_W
) (
  input logic Clock,
  input logic Reset,
  unidade_controle_fsm_if.master bus
);
  uc_state_t state_q, state_d;
  logic run_q;
  logic [2:0] op;
  logic [RSEL_W-1:0] rx, ry;
  logic [NREG-1:0] rx_oh, ry_oh;
  logic mv_go, legal, multi, t0, t1, t2, t3;
  assign op = bus.Instrucao[IW-1 -: 3];
  assign rx = bus.Instrucao[2*RSEL_W-1 -: RSEL_W];
  assign ry = bus.Instrucao[RSEL_W-1:0];
  dec_onehot #(.W(RSEL_W)) u_dec_rx (.a_i(rx), .y_o(rx_oh));
  dec_onehot #(.W(RSEL_W)) u_dec_ry (.a_i(ry), .y_o(ry_oh));
`ifdef UC_MVNZ_EN
  // mvnz only moves when G is non-zero; Done fires either way
  assign mv_go = (op == OP_MV) || (op == OP_MVNZ && bus.GNZ);
  assign legal = op inside {OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_MVNZ};
`else
  logic unused_gnz;
  assign unused_gnz = bus.GNZ;
  assign mv_go = (op == OP_MV);
  assign legal = op inside {OP_MV, OP_MVI, OP_ADD, OP_SUB};
`endif
  assign multi = (op == OP_ADD) || (op == OP_SUB);
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= bus.Run;
    end
  end
  // run_q tracks Run even while busy, so an edge seen mid-instruction is never replayed
  always_comb begin
    state_d = state_q == IDLE ? ((bus.Run && !run_q) ? T0 : IDLE) :
              state_q == T0   ? T1 :
              state_q == T1   ? (multi ? T2 : IDLE) :
              state_q == T2   ? T3 : IDLE;
  end
  assign t0 = state_q == T0;
  assign t1 = state_q == T1;
  assign t2 = state_q == T2;
  assign t3 = state_q == T3;
  assign bus.IRin    = t0;
  assign bus.DINout  = t0 || (t1 && op == OP_MVI);
  assign bus.Rin     = ((t1 && (mv_go || op == OP_MVI)) || t3) ? rx_oh : '0;
  assign bus.Rout    = (t1 && mv_go) ? ry_oh : (t1 && multi) ? rx_oh : t2 ? ry_oh : '0;
  assign bus.Ain     = t1 && multi;
  assign bus.Gin     = t2;
  assign bus.Gout    = t3;
  assign bus.AddSub  = t2 && op == OP_SUB;
  assign bus.Done    = (t1 && !multi) || t3;
  assign bus.Busy    = state_q != IDLE;
  assign bus.Illegal = t1 && !legal;
endmodule

// File: tb/tb_unidade_controle_fsm.sv
// tb_unidade_controle_fsm: directed scoreboard bench for the control unit (NREG=8 and NREG=4)
module tb_unidade_controle_fsm;
  typedef struct packed {
    logic [7:0] rin;
    logic [7:0] rout;
    logic irin, ain, gin, gout, dinout, addsub, done, busy, illegal;
  } ov_t;

  logic Clock = 1'b0;
  logic Reset;
  int errors = 0;
  int checks = 0;
  ov_t exp_q[$];
  string tag_q[$];
  bit sel_q[$];

  always #5 Clock = ~Clock;

  unidade_controle_fsm_if #(.NREG(8)) bus8 ();
  unidade_controle_fsm_if #(.NREG(4)) bus4 ();
  unidade_controle_fsm #(.NREG(8)) dut8 (.Clock(Clock), .Reset(Reset), .bus(bus8));
  unidade_controle_fsm #(.NREG(4)) dut4 (.Clock(Clock), .Reset(Reset), .bus(bus4));

  function automatic ov_t ov(logic [7:0] rin, logic [7:0] rout, logic irin, logic ain,
                             logic gin, logic gout, logic dinout, logic addsub,
                             logic done, logic busy, logic illegal);
    ov_t v;
    v.rin = rin; v.rout = rout; v.irin = irin; v.ain = ain; v.gin = gin; v.gout = gout;
    v.dinout = dinout; v.addsub = addsub; v.done = done; v.busy = busy; v.illegal = illegal;
    return v;
  endfunction

  function automatic ov_t obs(bit sel);
    ov_t o;
    o.rin     = sel ? {4'b0, bus4.Rin} : bus8.Rin;
    o.rout    = sel ? {4'b0, bus4.Rout} : bus8.Rout;
    o.irin    = sel ? bus4.IRin : bus8.IRin;
    o.ain     = sel ? bus4.Ain : bus8.Ain;
    o.gin     = sel ? bus4.Gin : bus8.Gin;
    o.gout    = sel ? bus4.Gout : bus8.Gout;
    o.dinout  = sel ? bus4.DINout : bus8.DINout;
    o.addsub  = sel ? bus4.AddSub : bus8.AddSub;
    o.done    = sel ? bus4.Done : bus8.Done;
    o.busy    = sel ? bus4.Busy : bus8.Busy;
    o.illegal = sel ? bus4.Illegal : bus8.Illegal;
    return o;
  endfunction

  task automatic push(input bit sel, input string tag, input ov_t v);
    sel_q.push_back(sel);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check_now();
    ov_t e, o;
    string t;
    bit s;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    s = sel_q.pop_front();
    o = obs(s);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    check_now();
  endtask

  ov_t z, f0;

  initial begin
    z  = ov(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    f0 = ov(8'h00, 8'h00, 1, 0, 0, 0, 1, 0, 0, 1, 0);
    Reset = 1'b1;
    bus8.Run = 1'b0; bus8.Instrucao = '0; bus8.GNZ = 1'b0;
    bus4.Run = 1'b0; bus4.Instrucao = '0; bus4.GNZ = 1'b0;
    #3;
    push(0, "reset_state", z); check_now();
    @(posedge Clock); #1;
    Reset = 1'b0;
    push(0, "idle_after_reset", z); tick();

    // mv R2,R5
    bus8.Run = 1'b1; bus8.Instrucao = 9'b000_010_101;
    push(0, "mv_t0", f0); tick();
    push(0, "mv_t1", ov(8'h04, 8'h20, 0, 0, 0, 0, 0, 0, 1, 1, 0)); tick();
    bus8.Run = 1'b0;
    push(0, "mv_idle", z); tick();

    // mvi R6
    bus8.Run = 1'b1; bus8.Instrucao = 9'b001_110_000;
    push(0, "mvi_t0", f0); tick();
    push(0, "mvi_t1", ov(8'h40, 8'h00, 0, 0, 0, 0, 1, 0, 1, 1, 0)); tick();
    bus8.Run = 1'b0;
    push(0, "mvi_idle", z); tick();

    // add R1,R3 with Run held high afterwards
    bus8.Run = 1'b1; bus8.Instrucao = 9'b010_001_011;
    push(0, "add_t0", f0); tick();
    push(0, "add_t1", ov(8'h00, 8'h02, 0, 1, 0, 0, 0, 0, 0, 1, 0)); tick();
    push(0, "add_t2", ov(8'h00, 8'h08, 0, 0, 1, 0, 0, 0, 0, 1, 0)); tick();
    push(0, "add_t3", ov(8'h02, 8'h00, 0, 0, 0, 1, 0, 0, 1, 1, 0)); tick();
    for (int i = 0; i < 5; i++) begin
      push(0, "run_held_idle", z); tick();
    end
    bus8.Run = 1'b0;
    push(0, "run_low_idle", z); tick();

    // sub R1,R3 with a Run edge while busy that must not be replayed
    bus8.Run = 1'b1; bus8.Instrucao = 9'b011_001_011;
    push(0, "sub_t0", f0); tick();
    push(0, "sub_t1", ov(8'h00, 8'h02, 0, 1, 0, 0, 0, 0, 0, 1, 0)); tick();
    bus8.Run = 1'b0;
    push(0, "sub_t2", ov(8'h00, 8'h08, 0, 0, 1, 0, 0, 1, 0, 1, 0)); tick();
    bus8.Run = 1'b1;
    push(0, "sub_t3", ov(8'h02, 8'h00, 0, 0, 0, 1, 0, 0, 1, 1, 0)); tick();
    push(0, "busy_edge_ignored_a", z); tick();
    push(0, "busy_edge_ignored_b", z); tick();
    bus8.Run = 1'b0;
    push(0, "sub_idle", z); tick();

    // async reset during T2 of add R1,R3
    bus8.Run = 1'b1; bus8.Instrucao = 9'b010_001_011;
    push(0, "rst_add_t0", f0); tick();
    push(0, "rst_add_t1", ov(8'h00, 8'h02, 0, 1, 0, 0, 0, 0, 0, 1, 0)); tick();
    push(0, "rst_add_t2", ov(8'h00, 8'h08, 0, 0, 1, 0, 0, 0, 0, 1, 0)); tick();
    #2;
    Reset = 1'b1; bus8.Run = 1'b0;
    #1;
    push(0, "async_reset_outputs", z); check_now();
    @(posedge Clock); #1;
    Reset = 1'b0;
    push(0, "idle_after_midreset", z); tick();

    // mvnz R0,R7 with GNZ=0 then GNZ=1
    bus8.Run = 1'b1; bus8.Instrucao = 9'b100_000_111; bus8.GNZ = 1'b0;
    push(0, "mvnz0_t0", f0); tick();
`ifdef UC_MVNZ_EN
    push(0, "mvnz0_t1", ov(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1, 0)); tick();
`else
    push(0, "mvnz0_t1", ov(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1, 1)); tick();
`endif
    bus8.Run = 1'b0;
    push(0, "mvnz0_idle", z); tick();
    bus8.Run = 1'b1; bus8.GNZ = 1'b1;
    push(0, "mvnz1_t0", f0); tick();
`ifdef UC_MVNZ_EN
    push(0, "mvnz1_t1", ov(8'h01, 8'h80, 0, 0, 0, 0, 0, 0, 1, 1, 0)); tick();
`else
    push(0, "mvnz1_t1", ov(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1, 1)); tick();
`endif
    bus8.Run = 1'b0; bus8.GNZ = 1'b0;
    push(0, "mvnz1_idle", z); tick();

    // undefined opcode 111
    bus8.Run = 1'b1; bus8.Instrucao = 9'b111_011_010;
    push(0, "ill8_t0", f0); tick();
    push(0, "ill8_t1", ov(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1, 1)); tick();
    bus8.Run = 1'b0;
    push(0, "ill8_idle", z); tick();

    // NREG=4: mv R3,R0 then opcode 111
    bus4.Run = 1'b1; bus4.Instrucao = 7'b000_11_00;
    push(1, "n4_mv_t0", f0); tick();
    push(1, "n4_mv_t1", ov(8'h08, 8'h01, 0, 0, 0, 0, 0, 0, 1, 1, 0)); tick();
    bus4.Run = 1'b0;
    push(1, "n4_mv_idle", z); tick();
    bus4.Run = 1'b1; bus4.Instrucao = 7'b111_00_00;
    push(1, "n4_ill_t0", f0); tick();
    push(1, "n4_ill_t1", ov(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1, 1)); tick();
    bus4.Run = 1'b0;
    push(1, "n4_ill_idle", z); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/unidade_controle_fsm.md
# unidade_controle_fsm

Parametrised, registered control unit for the multicycle processor datapath. It sequences fetch and execute steps with an internal state machine, which replaces the external 2-bit step counter. It starts on a rising edge of `Run` and generates one-hot register enables for any power-of-two register count. It completes the full `add`/`sub` three-step sequence, and can optionally compile in a conditional move (`mvnz`).

## Interface
Parameters:
- `NREG`, 8, number of general registers; power of two, minimum 2.
- `RSEL_W`, `$clog2(NREG)`, width of each register-select field (derived; do not override).
- `IW`, `3+2*RSEL_W`, instruction width (derived).

Ports:
- `Clock`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Run`  in  1  start request; only its rising edge is acted on.
- `Instrucao`  in  IW  IR contents; fields: `[IW-1:IW-3]` opcode, Rx next `RSEL_W` bits, Ry lowest `RSEL_W` bits.
- `GNZ`  in  1  high when datapath register G is non-zero (used by `mvnz`).
- `IRin`  out  1  loads IR.
- `Rin`  out  NREG  one-hot write enable for R0..R(NREG-1).
- `Rout`  out  NREG  one-hot bus drive for R0..R(NREG-1).
- `Ain`, `Gin`, `Gout`, `DINout`  out  1 each  A load, G load, G bus drive, DIN bus drive.
- `AddSub`  out  1  ALU mode: 0 = add, 1 = subtract.
- `Done`  out  1  final step of the current instruction.
- `Busy`  out  1  high whenever state ≠ IDLE.
- `Illegal`  out  1  pulses in T1 for an undefined opcode.

## Operation
- States: IDLE, T0, T1, T2, T3. State is held in a register; all outputs are decoded combinationally from the state and `Instrucao` (Moore outputs plus a field decode).
- `Run_d` register samples `Run` every cycle.
- IDLE → T0 when `Run && !Run_d`. Otherwise IDLE holds and all outputs are 0.
- T0 (fetch): `IRin=1`, `DINout=1`. Always moves to T1. `Instrucao` is valid from T1 onward.
- Opcodes:
  - `000` mv Rx,Ry. T1: `Rout=onehot(Ry)`, `Rin=onehot(Rx)`, `Done`.
  - `001` mvi Rx,#D. T1: `DINout`, `Rin=onehot(Rx)`, `Done`. The immediate must be on DIN during T1.
  - `010` add Rx,Ry.
    - T1: `Rout=onehot(Rx)`, `Ain`.
    - T2: `Rout=onehot(Ry)`, `Gin`, `AddSub=0`.
    - T3: `Gout`, `Rin=onehot(Rx)`, `Done`.
  - `011` sub Rx,Ry. Same as add, with `AddSub=1` in T2. `AddSub` is 0 in every other state.
  - `100` mvnz (macro only). T1: if `GNZ`, same enables as mv; `Done` asserts regardless of `GNZ`.
  - All other opcodes: T1 asserts `Done` and `Illegal` only; no register enables.
- Next-state rule: any state with `Done` high → IDLE.
- A new instruction requires `Run` to go low and then high again. `Run` held high after `Done` does not restart.
- Rx = Ry is legal and needs no special case.
- `Rin` and `Rout` are never both nonzero, except in mv/mvnz T1.

## Timing
- Reset (asynchronous, at any time, including mid-instruction): state = IDLE and `Run_d` = 0. Every output reads 0 immediately.
- Latency from the `Run` rising edge sampled at edge k:
  - T0 is during cycle k+1.
  - mv/mvi/mvnz/illegal: `Done` in cycle k+2.
  - add/sub: `Done` in cycle k+4.
- `Done`, `Illegal`, `IRin`: exactly one cycle wide per instruction.
- `Busy` falls in the cycle after `Done`. The earliest restart is `Run` low for ≥1 sampled edge, then high.
- A `Run` edge while Busy is ignored. `Run_d` still tracks, so this edge is not replayed later.

## Configuration
- `UC_MVNZ_EN` defined: opcode `100` executes mvnz as described.
- `UC_MVNZ_EN` undefined: opcode `100` is illegal (`Done`+`Illegal` in T1). The `GNZ` port is present but ignored.

## Structure
- Package `uc_pkg`:
  - opcode localparams `OP_MV`, `OP_MVI`, `OP_ADD`, `OP_SUB`, `OP_MVNZ`;
  - state enum `uc_state_t` {IDLE, T0, T1, T2, T3}.
- One sub-module, `dec_onehot #(W)`: W-bit binary to 2^W one-hot decoder. Instantiated twice, for Rx and Ry.

## Test plan
All scenarios use NREG=8 and 9-bit instructions unless stated otherwise.
- Reset asserted during T2 of `add R1,R3` → all outputs 0 at once. After release: state IDLE, `Busy=0`.
- mv R2,R5 (`000_010_101`), `Run` 0→1 → T0: `IRin=DINout=1`. Next cycle: `Rin=8'b00000100`, `Rout=8'b00100000`, `Done=1`. Then `Busy=0`.
- add R1,R3 (`010_001_011`) → T1: `Rout=8'b00000010`, `Ain`. T2: `Rout=8'b00001000`, `Gin`, `AddSub=0`. T3: `Gout`, `Rin=8'b00000010`, `Done`. Repeat with sub (`011_001_011`) → identical except `AddSub=1` in T2.
- `Run` held high through `Done` and 5 further cycles → stays IDLE. Drop `Run` for 1 cycle and raise it → T0 on the next edge.
- mvnz R0,R7 (`100_000_111`) with `UC_MVNZ_EN`:
  - `GNZ=0` → T1 `Done` only, `Rin=Rout=0`.
  - `GNZ=1` → `Rin=8'b00000001`, `Rout=8'b10000000`.
  - Without the macro → `Done=Illegal=1`, no enables.
- NREG=4 (IW=7), mv R3,R0 (`000_11_00`) → T1: `Rin=4'b1000`, `Rout=4'b0001`, `Done`. Opcode `111` → `Illegal` pulse.
